// File: rtl/encoder_4to2_queued.sv
// Queued N-to-log2(N) encoder with a registered valid/ready output and a sticky drop flag.
// Define ENC_ROUND_ROBIN_EN for round-robin selection; the default is highest-index priority.
module encoder_4to2_queued #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         flush_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic [N-1:0] pending_o,
    output logic         drop_o
);

    logic [N-1:0] pending_q;
    logic         valid_q;
    logic [W-1:0] code_q;
    logic         drop_q;

    logic [W-1:0] sel;
    logic         load;
    logic [N-1:0] load_mask;
    logic [N-1:0] lost;

`ifdef ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q;
    logic [W-1:0] idx;
    logic         found;

    // Search starts just above the last served index and wraps around.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = ptr_q + W'(i);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (flush_i) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= sel;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int k = 0; k < N; k++) begin
            if (pending_q[k]) begin
                sel = W'(k);
            end
        end
    end
`endif

    assign load      = (~valid_q | out_ready) & (|pending_q);
    assign load_mask = load ? (N'(1) << sel) : '0;
    // A request on a bit that stays pending merges into it and is lost.
    assign lost      = req_i & pending_q & ~load_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            drop_q    <= 1'b0;
        end else if (flush_i) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            drop_q    <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~load_mask) | req_i;
            if (|lost) begin
                drop_q <= 1'b1;
            end
            if (load) begin
                valid_q <= 1'b1;
                code_q  <= sel;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign pending_o = pending_q;
    assign drop_o    = drop_q;

endmodule

// File: tb/tb_encoder_4to2_queued.sv
// Directed self-checking bench for encoder_4to2_queued (N=4).
// Status vectors are {out_valid, out_code[1:0], pending_o[3:0], drop_o}.
module tb_encoder_4to2_queued;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_i;
    logic       flush_i;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic [3:0] pending_o;
    logic       drop_o;

    int checks;
    int failures;

    encoder_4to2_queued #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .flush_i   (flush_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .pending_o (pending_o),
        .drop_o    (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_i     = '0;
        flush_i   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] got;
        do_reset();
        got = {out_valid, out_code, pending_o, drop_o};
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got=%b required=%b", got, 8'h00);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [3];
        logic [3:0] stim [3];
        logic [7:0] got;
        exp  = '{{1'b0, 2'd0, 4'b0100, 1'b0},
                 {1'b1, 2'd2, 4'b0000, 1'b0},
                 {1'b0, 2'd0, 4'b0000, 1'b0}};
        stim = '{4'b0100, 4'b0000, 4'b0000};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_i = stim[i];
            tick();
            got = {out_valid, out_code, pending_o, drop_o};
            checks++;
            if (exp[i][7] || i == 0 ? (got !== exp[i])
                : ({got[7], got[4:0]} !== {exp[i][7], exp[i][4:0]})) begin
                failures++;
                $display("FAIL single_%0d got=%b required=%b", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] exp [5];
        logic [7:0] got;
        exp = '{{1'b0, 2'd0, 4'b1011, 1'b0},
                {1'b1, 2'd3, 4'b0011, 1'b0},
                {1'b1, 2'd1, 4'b0001, 1'b0},
                {1'b1, 2'd0, 4'b0000, 1'b0},
                {1'b0, 2'd0, 4'b0000, 1'b0}};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_i = (i == 0) ? 4'b1011 : 4'b0000;
            tick();
            got = {out_valid, out_code, pending_o, drop_o};
            checks++;
            if (exp[i][7] || i == 0 ? (got !== exp[i])
                : ({got[7], got[4:0]} !== {exp[i][7], exp[i][4:0]})) begin
                failures++;
                $display("FAIL priority_%0d got=%b required=%b", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [9];
        logic [3:0] stim [9];
        logic [7:0] got;
        exp  = '{{1'b0, 2'd0, 4'b0001, 1'b0},
                 {1'b1, 2'd0, 4'b1000, 1'b0},
                 {1'b1, 2'd0, 4'b1000, 1'b0},
                 {1'b1, 2'd0, 4'b1000, 1'b0},
                 {1'b1, 2'd0, 4'b1000, 1'b0},
                 {1'b1, 2'd0, 4'b1000, 1'b0},
                 {1'b1, 2'd0, 4'b1000, 1'b0},
                 {1'b1, 2'd3, 4'b0000, 1'b0},
                 {1'b0, 2'd0, 4'b0000, 1'b0}};
        stim = '{4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req_i     = stim[i];
            out_ready = (i >= 7);
            tick();
            got = {out_valid, out_code, pending_o, drop_o};
            checks++;
            if (exp[i][7] || i == 0 ? (got !== exp[i])
                : ({got[7], got[4:0]} !== {exp[i][7], exp[i][4:0]})) begin
                failures++;
                $display("FAIL backpressure_%0d got=%b required=%b", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_drop_flush();
        logic [7:0] exp [12];
        logic [3:0] stim [12];
        logic       rdy [12];
        logic       fl [12];
        logic [7:0] got;
        exp  = '{{1'b0, 2'd0, 4'b1000, 1'b0},
                 {1'b1, 2'd3, 4'b0000, 1'b0},
                 {1'b1, 2'd3, 4'b0010, 1'b0},
                 {1'b1, 2'd3, 4'b0010, 1'b1},
                 {1'b1, 2'd3, 4'b0010, 1'b1},
                 {1'b1, 2'd1, 4'b0000, 1'b1},
                 {1'b0, 2'd0, 4'b0000, 1'b1},
                 {1'b0, 2'd0, 4'b0000, 1'b1},
                 {1'b0, 2'd0, 4'b0100, 1'b1},
                 {1'b1, 2'd2, 4'b0000, 1'b1},
                 {1'b0, 2'd0, 4'b0000, 1'b0},
                 {1'b0, 2'd0, 4'b0000, 1'b0}};
        stim = '{4'b1000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
        rdy  = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        fl   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req_i     = stim[i];
            out_ready = rdy[i];
            flush_i   = fl[i];
            tick();
            got = {out_valid, out_code, pending_o, drop_o};
            checks++;
            if (exp[i][7] || i >= 10 ? (got !== exp[i])
                : ({got[7], got[4:0]} !== {exp[i][7], exp[i][4:0]})) begin
                failures++;
                $display("FAIL drop_flush_%0d got=%b required=%b", i, got, exp[i]);
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic test_rereq_async_reset();
        logic [7:0] got;
        logic [7:0] exp_load;
        logic [3:0] rereq;
`ifdef ENC_ROUND_ROBIN_EN
        rereq    = 4'b0010;
        exp_load = {1'b1, 2'd1, 4'b1110, 1'b0};
`else
        rereq    = 4'b1000;
        exp_load = {1'b1, 2'd3, 4'b1110, 1'b0};
`endif
        do_reset();
        req_i = 4'b1110;
        tick();
        req_i = rereq;
        tick();
        got = {out_valid, out_code, pending_o, drop_o};
        checks++;
        if (got !== exp_load) begin
            failures++;
            $display("FAIL rereq_load got=%b required=%b", got, exp_load);
        end
        req_i = 4'b0000;
        tick();
        got = {out_valid, out_code, pending_o, drop_o};
        checks++;
        if (got !== exp_load) begin
            failures++;
            $display("FAIL rereq_hold got=%b required=%b", got, exp_load);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {out_valid, out_code, pending_o, drop_o};
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got=%b required=%b", got, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [6];
        logic [7:0] got;
        exp = '{{1'b0, 2'd0, 4'b1111, 1'b0},
                {1'b1, 2'd1, 4'b1101, 1'b0},
                {1'b1, 2'd2, 4'b1001, 1'b0},
                {1'b1, 2'd3, 4'b0001, 1'b0},
                {1'b1, 2'd0, 4'b0000, 1'b0},
                {1'b0, 2'd0, 4'b0000, 1'b0}};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_i = (i == 0) ? 4'b1111 : 4'b0000;
            tick();
            got = {out_valid, out_code, pending_o, drop_o};
            checks++;
            if (exp[i][7] || i == 0 ? (got !== exp[i])
                : ({got[7], got[4:0]} !== {exp[i][7], exp[i][4:0]})) begin
                failures++;
                $display("FAIL round_robin_%0d got=%b required=%b", i, got, exp[i]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_i     = '0;
        flush_i   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
`ifdef ENC_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_priority();
`endif
        test_backpressure();
        test_drop_flush();
        test_rereq_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
